// File: rtl/fifo_ctrl_32_5_pkg.sv
// Shared types for the FIFO controller: memory control bundle and pointer helpers.
package fifo_ctrl_32_5_pkg;

  localparam int PTR_W = 5;

  // Control bundle driven towards the external word memory.
  typedef struct packed {
    logic             wr_vld;
    logic [PTR_W-1:0] wr_address;
    logic [PTR_W-1:0] rd_address;
  } m_32_5;

  // Advance a memory pointer, wrapping after the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input int unsigned        last);
    logic [PTR_W-1:0] r;
    if (p == PTR_W'(last)) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ctrl_32_5_skid.sv
// Small output skid FIFO holding words returned by the memory until the consumer takes them.
module fifo_skid_4 #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 4,
  localparam int CW     = $clog2(ENTRIES + 1),
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [IW-1:0]    head_q, head_d;
  logic [IW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next-state for pointers and occupancy; push and pop in one cycle leave occupancy unchanged.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      tail_d = (tail_q == IW'(ENTRIES - 1)) ? '0 : tail_q + IW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_i) begin
      head_d = (head_q == IW'(ENTRIES - 1)) ? '0 : head_q + IW'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Word storage; contents need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fifo_ctrl_32_5.sv
// FIFO controller over an external 2-cycle-latency word memory, with a skid buffer on the output.
module fifo_ctrl_32_5
  import fifo_ctrl_32_5_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int SKID   = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] count,
  output m_32_5            m,
  output logic [WIDTH-1:0] m_wr_data,
  input  logic [WIDTH-1:0] m_rd_data
);

  localparam int SKW   = $clog2(SKID + 1);
  localparam int OCC_W = SKW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  // bit 0: read issued last cycle, bit 1: read data present on m_rd_data this cycle
  logic [1:0]       inflight_q, inflight_d;

  logic             push_s;
  logic             issue_s;
  logic             pop_s;
  logic             capture_s;
  logic [OCC_W-1:0] occ_s;
  logic [SKW-1:0]   skid_cnt_s;
  logic [WIDTH-1:0] skid_head_s;

  // Handshakes, read issue and memory port drive; reset forces every strobe and address low.
  always_comb begin
    in_rdy    = 1'b0;
    push_s    = 1'b0;
    issue_s   = 1'b0;
    out_vld   = 1'b0;
    pop_s     = 1'b0;
    m         = '0;
    m_wr_data = '0;

    // Words already in the skid plus reads still in the pipe must never exceed the skid size.
    occ_s     = OCC_W'(skid_cnt_s) + OCC_W'(inflight_q[0]) + OCC_W'(inflight_q[1]);
    capture_s = inflight_q[1];

    if (reset) begin
      in_rdy  = 1'b0;
      issue_s = 1'b0;
      out_vld = 1'b0;
    end else begin
      in_rdy  = (count_q < CNT_W'(DEPTH));
      issue_s = (mem_cnt_q != '0) && (occ_s < OCC_W'(SKID));
      out_vld = (skid_cnt_s != '0);
    end

    push_s = in_vld && in_rdy;
    pop_s  = out_vld && out_rdy;

    m.wr_vld = push_s;
    if (reset) begin
      m.wr_address = '0;
      m.rd_address = '0;
    end else begin
      m.wr_address = wr_ptr_q;
      m.rd_address = rd_ptr_q;
    end

    if (push_s) begin
      m_wr_data = in_data;
    end else begin
      m_wr_data = '0;
    end
  end

  // Next-state for pointers, memory occupancy, read pipeline and total count.
  always_comb begin
    wr_ptr_d   = push_s  ? ptr_inc(wr_ptr_q, DEPTH - 1) : wr_ptr_q;
    rd_ptr_d   = issue_s ? ptr_inc(rd_ptr_q, DEPTH - 1) : rd_ptr_q;
    inflight_d = {inflight_q[0], issue_s};

    case ({push_s, issue_s})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase

    // Total count only changes at the two boundaries; internal moves leave it alone.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Controller state; reset discards stored and in-flight words but leaves memory contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  fifo_skid_4 #(
    .WIDTH   (WIDTH),
    .ENTRIES (SKID)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (capture_s),
    .push_data_i (m_rd_data),
    .pop_i       (pop_s),
    .count_o     (skid_cnt_s),
    .head_o      (skid_head_s)
  );

  assign out_data = skid_head_s;
  assign count    = count_q;

endmodule

// File: tb/tb_fifo_ctrl_32_5.sv
// Self-checking bench for fifo_ctrl_32_5 against a queue-based reference of FIFO behaviour.
module tb_fifo_ctrl_32_5;
  import fifo_ctrl_32_5_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_rdy;
  logic        out_vld;
  logic [31:0] out_data;
  logic        out_rdy;
  logic [5:0]  count;
  m_32_5       m;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;

  fifo_ctrl_32_5 dut (
    .clk       (clk),
    .reset     (reset),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_rdy    (in_rdy),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .count     (count),
    .m         (m),
    .m_wr_data (m_wr_data),
    .m_rd_data (m_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory: write on the edge, read data appears two cycles after the address.
  logic [31:0] mem_m [32];
  logic [31:0] rd_p1;
  always @(posedge clk) begin
    if (m.wr_vld) mem_m[m.wr_address] <= m_wr_data;
    rd_p1     <= mem_m[m.rd_address];
    m_rd_data <= rd_p1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted words in order, total stored count, write slot.
  logic [31:0] mq [$];
  int          mcount = 0;
  int          wptr   = 0;
  int          n_push = 0;
  int          n_pop  = 0;

  logic        last_out_vld, last_in_rdy, last_pop;
  logic [31:0] last_out_data;
  logic [5:0]  last_count;
  logic [4:0]  last_wr_addr;

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic run_cycle(input logic rst, input logic iv, input logic [31:0] id, input logic ordy);
    logic exp_push;
    logic obs_pop;
    reset   = rst;
    in_vld  = iv;
    in_data = id;
    out_rdy = ordy;
    @(negedge clk);
    last_out_vld  = out_vld;
    last_in_rdy   = in_rdy;
    last_out_data = out_data;
    last_count    = count;
    last_wr_addr  = m.wr_address;
    last_pop      = out_vld && ordy;
    if (rst) begin
      check_eq("rst_in_rdy", in_rdy, 1'b0);
      check_eq("rst_out_vld", out_vld, 1'b0);
      check_eq("rst_wr_vld", m.wr_vld, 1'b0);
      check_eq("rst_rd_addr", m.rd_address, 5'd0);
      check_eq("rst_wr_data", m_wr_data, 32'd0);
      mq.delete();
      mcount = 0;
      wptr   = 0;
    end else begin
      exp_push = iv && (mcount < 32);
      obs_pop  = out_vld && ordy;
      check_eq("count", count, mcount);
      check_eq("in_rdy", in_rdy, (mcount < 32));
      check_eq("wr_vld", m.wr_vld, exp_push);
      if (exp_push) begin
        check_eq("wr_addr", m.wr_address, wptr);
        check_eq("wr_data", m_wr_data, id);
      end
      if (out_vld) begin
        if (mq.size() == 0) check_eq("spurious_vld", out_vld, 1'b0);
        else                check_eq("out_data", out_data, mq[0]);
      end
      if (obs_pop && mq.size() > 0) begin
        void'(mq.pop_front());
        mcount--;
        n_pop++;
      end
      if (exp_push) begin
        mq.push_back(id);
        mcount++;
        n_push++;
        wptr = (wptr + 1) % 32;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (mq.size() > 0 && n < budget) begin
      run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
      n++;
    end
    check_eq("drain_empty", mq.size(), 32'd0);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    int   pops;
    int   base;
    int   cyc;
    logic iv, ordy;

    reset = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;

    // Reset with input pressure, then idle.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_cycle(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check_eq("init_count", last_count, 6'd0);
    check_eq("init_in_rdy", last_in_rdy, 1'b1);
    check_eq("init_out_vld", last_out_vld, 1'b0);

    // Single word latency through an empty FIFO.
    for (int c = 0; c < 7; c++) begin
      run_cycle(1'b0, (c == 0), 32'h1111_1111, 1'b1);
      check_eq("lat_vld", last_out_vld, (c == 4));
      if (c == 4) check_eq("lat_data", last_out_data, 32'h1111_1111);
      if (c == 5) check_eq("lat_count_after_pop", last_count, 6'd0);
    end

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 32; i++) run_cycle(1'b0, 1'b1, i, 1'b0);
    run_cycle(1'b0, 1'b1, 32'hDEAD_0033, 1'b0);
    check_eq("full_count", last_count, 6'd32);
    check_eq("full_in_rdy", last_in_rdy, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 32'd0, 1'b0);
    // Push and pop together while full: push refused, one word leaves.
    run_cycle(1'b0, 1'b1, 32'hBEEF_0040, 1'b1);
    check_eq("full_pp_in_rdy", last_in_rdy, 1'b0);
    check_eq("full_pp_pop", last_pop, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check_eq("full_pp_count", last_count, 6'd31);
    drain(200);

    // Continuous streaming: one word per cycle after the pipeline fills.
    for (int c = 0; c < 110; c++) begin
      run_cycle(1'b0, (c < 100), 32'h0000_1000 + c, 1'b1);
      check_eq("thru_vld", last_out_vld, (c >= 4 && c < 104));
    end
    drain(50);

    // Random handshakes on both sides.
    base = n_push;
    cyc  = 0;
    while ((n_push - base) < 1000 && cyc < 8000) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      run_cycle(1'b0, iv, $urandom(), ordy);
      cyc++;
    end
    check_eq("rand_pushed", ((n_push - base) >= 1000), 1'b1);
    drain(400);

    // Reset mid-operation with 20 words stored and reads in flight.
    for (int i = 0; i < 22; i++) run_cycle(1'b0, 1'b1, 32'h0000_2000 + i, 1'b0);
    for (int i = 0; i < 6; i++)  run_cycle(1'b0, 1'b0, 32'd0, 1'b0);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check_eq("pre_rst_count", last_count, 6'd20);
    run_cycle(1'b1, 1'b1, 32'h5A5A_5A5A, 1'b1);
    run_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check_eq("post_rst_count", last_count, 6'd0);
    check_eq("post_rst_vld", last_out_vld, 1'b0);
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b0, (c == 0), 32'hA5A5_A5A5, 1'b1);
      if (c == 0) check_eq("post_rst_wr_addr", last_wr_addr, 5'd0);
      check_eq("post_rst_vld_seq", last_out_vld, (c == 4));
      if (last_pop) pops++;
    end
    check_eq("post_rst_pops", pops, 32'd1);
    check_eq("post_rst_empty", mq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
